// File: rtl/axi4_burst_write_master_if.sv
// AXI4 write-only channel bundle (AW, W, B) between a burst write master and its slave.
interface axi4_burst_write_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awuser;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wuser;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
               awregion, awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
               awregion, awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi4_burst_write_master.sv
// Single-outstanding AXI4 INCR write master: one command + data stream -> one burst -> status.
module axi4_burst_write_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int ID_VALUE   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic [1:0]            done_resp_o,
    output logic                  done_err_o,
    axi4_burst_write_master_if.master axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [1:0]            resp_q, resp_d;
    logic                  err_q, err_d;

    // Byte offset one past the last beat within the 4KB page; 4096 exactly is still legal.
    logic [13:0] span, end_off;
    logic        reject;
    assign span    = 14'({6'd0, cmd_len_i} + 14'd1) << SIZE;
    assign end_off = {2'b00, cmd_addr_i[11:0]} + span;
    assign reject  = (|cmd_addr_i[SIZE-1:0]) || (end_off > 14'd4096);

    logic unused_bid;
    assign unused_bid = ^axi.bid;

    assign axi.awid     = ID_WIDTH'(ID_VALUE);
    assign axi.awaddr   = addr_q;
    assign axi.awlen    = len_q;
    assign axi.awsize   = 3'(SIZE);
    assign axi.awburst  = 2'b01;
    assign axi.awlock   = 1'b0;
    assign axi.awcache  = 4'b0011;
    assign axi.awprot   = 3'b000;
    assign axi.awqos    = 4'd0;
    assign axi.awregion = 4'd0;
    assign axi.awuser   = 1'b0;
    assign axi.wdata    = s_data_i;
    assign axi.wstrb    = '1;
    assign axi.wuser    = 1'b0;
    assign done_resp_o  = resp_q;
    assign done_err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        err_d        = err_q;
        cmd_ready_o  = 1'b0;
        s_ready_o    = 1'b0;
        done_valid_o = 1'b0;
        axi.awvalid  = 1'b0;
        axi.wvalid   = 1'b0;
        axi.wlast    = 1'b0;
        axi.bready   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = !rst_i;
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    len_d  = cmd_len_i;
                    cnt_d  = '0;
                    resp_d = 2'b00;
                    err_d  = reject;
                    state_d = reject ? DONE : ADDR;
                end
            end
            ADDR: begin
                axi.awvalid = 1'b1;
                if (axi.awready) state_d = DATA;
            end
            DATA: begin
                // Stream is wired straight onto W; the slave's WREADY throttles the source.
                axi.wvalid = s_valid_i;
                s_ready_o  = axi.wready;
                axi.wlast  = (cnt_q == {1'b0, len_q});
                if (s_valid_i && axi.wready) begin
                    if (axi.wlast) state_d = RESP;
                    else           cnt_d   = cnt_q + 9'd1;
                end
            end
            RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    resp_d  = axi.bresp;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_valid_o = 1'b1;
                if (done_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi4_burst_write_master.sv
// Directed bench: scripted AXI slave + data source around the burst write master.
module tb_axi4_burst_write_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [1:0]  done_resp;
    logic        done_err;

    int n_cmp = 0;
    int n_bad = 0;

    // slave / source configuration (written by the test sequence only)
    bit          wr_toggle = 1'b0;
    int          aw_stall = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic        src_on = 1'b0;
    int          src_count = 0;
    logic [31:0] src_base = '0;
    int          src_tag = 0;

    // slave / source state
    int src_idx = 0;
    int src_tag_seen = 0;
    int aw_wait = 0;
    bit w_fire = 1'b0;

    // monitor state
    int          aw_hs = 0, awv_cyc = 0, wv_cyc = 0, aw_unstable = 0;
    logic [31:0] last_awaddr = '0, aw_hold = '0;
    logic [7:0]  last_awlen = '0, len_hold = '0;
    bit          aw_prev_wait = 1'b0;
    logic [31:0] wdata_q[$];
    bit          wlast_q[$];

    always #5 clk = ~clk;

    axi4_burst_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

    axi4_burst_write_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .ID_VALUE(0)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .done_valid_o(done_valid), .done_ready_i(done_ready), .done_resp_o(done_resp), .done_err_o(done_err),
        .axi(axi)
    );

    assign axi.bid = '0;
    assign s_valid = src_on && (src_idx < src_count);
    assign s_data  = src_base + 32'(src_idx);

    always @(posedge clk) begin
        #1;
        if (rst) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
            aw_wait = 0; src_idx = 0; src_tag_seen = src_tag;
        end else begin
            if (src_tag != src_tag_seen) begin src_idx = 0; src_tag_seen = src_tag; end
            else if (w_fire) src_idx++;
            if (axi.awvalid === 1'b1) begin
                if (aw_wait >= aw_stall) axi.awready = 1'b1;
                else begin axi.awready = 1'b0; aw_wait++; end
            end else begin
                axi.awready = 1'b0; aw_wait = 0;
            end
            axi.wready = wr_toggle ? ~axi.wready : 1'b1;
            if (axi.bvalid) axi.bvalid = 1'b0;
            else if (axi.bready === 1'b1) begin axi.bvalid = 1'b1; axi.bresp = bresp_cfg; end
        end
    end

    always @(negedge clk) begin
        w_fire = (axi.wvalid === 1'b1) && (axi.wready === 1'b1);
        if (axi.awvalid === 1'b1) begin
            awv_cyc++;
            if (aw_prev_wait && (axi.awaddr !== aw_hold || axi.awlen !== len_hold)) aw_unstable++;
            aw_hold = axi.awaddr; len_hold = axi.awlen;
            if (axi.awready === 1'b1) begin aw_hs++; last_awaddr = axi.awaddr; last_awlen = axi.awlen; end
        end
        aw_prev_wait = (axi.awvalid === 1'b1) && (axi.awready !== 1'b1);
        if (axi.wvalid === 1'b1) wv_cyc++;
        if (w_fire) begin wdata_q.push_back(axi.wdata); wlast_q.push_back(axi.wlast); end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l);
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready === 1'b1) break;
            tick();
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            if (done_valid === 1'b1) break;
            tick();
        end
    endtask

    task automatic ack_done();
        done_ready = 1'b1; tick(); done_ready = 1'b0;
    endtask

    task automatic start_src(input logic [31:0] base, input int count);
        src_base = base; src_count = count; src_on = 1'b1; src_tag++;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        n_cmp++; if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_axi_valids: got %b want 0000", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready}); end
        n_cmp++; if ({s_ready, done_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_sready_done: got %b want 00", {s_ready, done_valid}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if ({done_resp, done_err} !== 3'b000) begin n_bad++; $display("FAIL post_rst_status: got %b want 000", {done_resp, done_err}); end
    endtask

    task automatic test_single();
        int nw0, ah0;
        start_src(32'hDEADBEEF, 1);
        nw0 = wdata_q.size(); ah0 = aw_hs;
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL single_early_hold: s_ready=%b want 0", s_ready); end
        send_cmd(32'h1000, 8'd0);
        n_cmp++; if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h1000 || axi.awlen !== 8'd0) begin
            n_bad++; $display("FAIL single_aw: valid=%b addr=%h len=%0d want 1/00001000/0", axi.awvalid, axi.awaddr, axi.awlen); end
        n_cmp++; if ({axi.awsize, axi.awburst, axi.awcache, axi.wstrb} !== {3'd2, 2'b01, 4'b0011, 4'hF}) begin
            n_bad++; $display("FAIL single_aw_consts: size=%0d burst=%b cache=%b strb=%h", axi.awsize, axi.awburst, axi.awcache, axi.wstrb); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL single_addr_hold: s_ready=%b want 0", s_ready); end
        wait_done();
        n_cmp++; if ({done_valid, done_resp, done_err} !== 4'b1000) begin
            n_bad++; $display("FAIL single_done: valid=%b resp=%b err=%b want 1/00/0", done_valid, done_resp, done_err); end
        tick();
        n_cmp++; if ({done_valid, cmd_ready} !== 2'b10) begin
            n_bad++; $display("FAIL single_done_hold: valid=%b cmd_ready=%b want 1/0", done_valid, cmd_ready); end
        ack_done();
        n_cmp++; if ({done_valid, cmd_ready} !== 2'b01) begin
            n_bad++; $display("FAIL single_done_ack: valid=%b cmd_ready=%b want 0/1", done_valid, cmd_ready); end
        n_cmp++; if (wdata_q.size() - nw0 != 1 || aw_hs - ah0 != 1) begin
            n_bad++; $display("FAIL single_counts: beats=%0d aw=%0d want 1/1", wdata_q.size() - nw0, aw_hs - ah0); end
        else begin
            n_cmp++; if (wdata_q[nw0] !== 32'hDEADBEEF || wlast_q[nw0] !== 1'b1) begin
                n_bad++; $display("FAIL single_beat: data=%h last=%b want deadbeef/1", wdata_q[nw0], wlast_q[nw0]); end
        end
        src_on = 1'b0;
    endtask

    task automatic test_wready_toggle();
        int nw0, ah0;
        wr_toggle = 1'b1;
        start_src(32'h100, 16);
        nw0 = wdata_q.size(); ah0 = aw_hs;
        send_cmd(32'h2000, 8'd15);
        wait_done();
        n_cmp++; if ({done_valid, done_resp, done_err} !== 4'b1000) begin
            n_bad++; $display("FAIL toggle_done: valid=%b resp=%b err=%b want 1/00/0", done_valid, done_resp, done_err); end
        n_cmp++; if (wdata_q.size() - nw0 != 16 || aw_hs - ah0 != 1 || last_awlen !== 8'd15) begin
            n_bad++; $display("FAIL toggle_counts: beats=%0d aw=%0d awlen=%0d want 16/1/15", wdata_q.size() - nw0, aw_hs - ah0, last_awlen); end
        for (int i = 0; i < 16 && nw0 + i < wdata_q.size(); i++) begin
            n_cmp++; if (wdata_q[nw0+i] !== 32'h100 + 32'(i) || wlast_q[nw0+i] !== (i == 15)) begin
                n_bad++; $display("FAIL toggle_beat%0d: data=%h last=%b want %h/%b", i, wdata_q[nw0+i], wlast_q[nw0+i], 32'h100 + 32'(i), i == 15); end
        end
        ack_done();
        wr_toggle = 1'b0; src_on = 1'b0;
    endtask

    task automatic test_max_len();
        int nw0, bad_data, lasts;
        start_src(32'h5000_0000, 256);
        nw0 = wdata_q.size();
        send_cmd(32'h0, 8'd255);
        wait_done();
        n_cmp++; if ({done_valid, done_err} !== 2'b10) begin n_bad++; $display("FAIL max_done: valid=%b err=%b want 1/0", done_valid, done_err); end
        n_cmp++; if (wdata_q.size() - nw0 != 256) begin n_bad++; $display("FAIL max_beats: got %0d want 256", wdata_q.size() - nw0); end
        bad_data = 0; lasts = 0;
        for (int i = nw0; i < wdata_q.size(); i++) begin
            if (wdata_q[i] !== 32'h5000_0000 + 32'(i - nw0)) bad_data++;
            if (wlast_q[i]) lasts++;
        end
        n_cmp++; if (bad_data != 0 || lasts != 1 || wlast_q[wdata_q.size()-1] !== 1'b1) begin
            n_bad++; $display("FAIL max_data: bad=%0d wlasts=%0d want 0/1 on final beat", bad_data, lasts); end
        ack_done();
        src_on = 1'b0;
    endtask

    task automatic test_4k_boundary();
        int ah0, awv0, wv0;
        start_src(32'h40, 4);
        ah0 = aw_hs;
        send_cmd(32'h0FF0, 8'd3);
        wait_done();
        n_cmp++; if ({done_valid, done_err} !== 2'b10 || aw_hs - ah0 != 1) begin
            n_bad++; $display("FAIL 4k_edge_ok: valid=%b err=%b aw=%0d want 1/0/1", done_valid, done_err, aw_hs - ah0); end
        ack_done();
        start_src(32'h50, 4);
        awv0 = awv_cyc; wv0 = wv_cyc;
        send_cmd(32'h0FF8, 8'd3);
        wait_done();
        n_cmp++; if ({done_valid, done_resp, done_err} !== 4'b1001) begin
            n_bad++; $display("FAIL 4k_cross_reject: valid=%b resp=%b err=%b want 1/00/1", done_valid, done_resp, done_err); end
        n_cmp++; if (awv_cyc - awv0 != 0 || wv_cyc - wv0 != 0) begin
            n_bad++; $display("FAIL 4k_cross_traffic: awvalid cycles=%0d wvalid cycles=%0d want 0/0", awv_cyc - awv0, wv_cyc - wv0); end
        ack_done();
        src_on = 1'b0;
    endtask

    task automatic test_unaligned();
        int awv0, wv0;
        awv0 = awv_cyc; wv0 = wv_cyc;
        send_cmd(32'h0002, 8'd0);
        wait_done();
        n_cmp++; if ({done_valid, done_resp, done_err} !== 4'b1001) begin
            n_bad++; $display("FAIL unaligned_reject: valid=%b resp=%b err=%b want 1/00/1", done_valid, done_resp, done_err); end
        n_cmp++; if (awv_cyc - awv0 != 0 || wv_cyc - wv0 != 0) begin
            n_bad++; $display("FAIL unaligned_traffic: awvalid cycles=%0d wvalid cycles=%0d want 0/0", awv_cyc - awv0, wv_cyc - wv0); end
        ack_done();
    endtask

    task automatic test_bresp_err();
        int nw0, awv0, un0;
        aw_stall = 5; bresp_cfg = 2'b10;
        start_src(32'hA0, 4);
        nw0 = wdata_q.size(); awv0 = awv_cyc; un0 = aw_unstable;
        send_cmd(32'h3000, 8'd3);
        wait_done();
        n_cmp++; if ({done_valid, done_resp, done_err} !== 4'b1100) begin
            n_bad++; $display("FAIL slverr_done: valid=%b resp=%b err=%b want 1/10/0", done_valid, done_resp, done_err); end
        n_cmp++; if (awv_cyc - awv0 != 6 || aw_unstable - un0 != 0 || last_awaddr !== 32'h3000) begin
            n_bad++; $display("FAIL slverr_aw_stall: awvalid cycles=%0d unstable=%0d addr=%h want 6/0/00003000", awv_cyc - awv0, aw_unstable - un0, last_awaddr); end
        n_cmp++; if (wdata_q.size() - nw0 != 4) begin n_bad++; $display("FAIL slverr_beats: got %0d want 4", wdata_q.size() - nw0); end
        ack_done();
        aw_stall = 0; bresp_cfg = 2'b00; src_on = 1'b0;
    endtask

    task automatic test_reset_midburst();
        int nw0;
        start_src(32'hB0, 8);
        nw0 = wdata_q.size();
        send_cmd(32'h4000, 8'd7);
        for (int i = 0; i < 200; i++) begin
            if (wdata_q.size() - nw0 >= 3) break;
            tick();
        end
        n_cmp++; if (wdata_q.size() - nw0 < 3) begin n_bad++; $display("FAIL midrst_progress: beats=%0d want >=3", wdata_q.size() - nw0); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({axi.awvalid, axi.wvalid, axi.bready, s_ready} !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_valids: aw/w/b/sready=%b want 0000", {axi.awvalid, axi.wvalid, axi.bready, s_ready}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle: cmd_ready=%b want 1", cmd_ready); end
        repeat (3) tick();
        n_cmp++; if (done_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_status: done_valid=%b want 0", done_valid); end
        start_src(32'hC0, 2);
        nw0 = wdata_q.size();
        send_cmd(32'h5000, 8'd1);
        wait_done();
        n_cmp++; if ({done_valid, done_resp, done_err} !== 4'b1000) begin
            n_bad++; $display("FAIL midrst_new_done: valid=%b resp=%b err=%b want 1/00/0", done_valid, done_resp, done_err); end
        n_cmp++; if (wdata_q.size() - nw0 != 2) begin n_bad++; $display("FAIL midrst_new_beats: got %0d want 2", wdata_q.size() - nw0); end
        else begin
            n_cmp++; if (wdata_q[nw0] !== 32'hC0 || wdata_q[nw0+1] !== 32'hC1 || wlast_q[nw0+1] !== 1'b1) begin
                n_bad++; $display("FAIL midrst_new_data: %h %h last=%b want c0 c1 1", wdata_q[nw0], wdata_q[nw0+1], wlast_q[nw0+1]); end
        end
        ack_done();
        src_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wready_toggle();
        test_max_len();
        test_4k_boundary();
        test_unaligned();
        test_bresp_err();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
